// File: rtl/i2c_pkg.sv
// Shared state encoding, bit-position constants and address helper for the
// AXI-Stream bridged I2C target.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WR_DATA   = 3'd3,
    ST_WR_ACK    = 3'd4,
    ST_RD_DATA   = 3'd5,
    ST_RD_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } i2c_slave_state_t;

  localparam int unsigned I2C_BIT_CNT_W = 4;
  localparam logic [I2C_BIT_CNT_W-1:0] I2C_ACK_BIT = 4'd8;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  function automatic logic addr_match(input logic [7:0] addr_byte,
                                      input logic [6:0] slave_addr);
    return (addr_byte[7:1] == slave_addr);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA input synchronizer with SCL edge and START/STOP condition detection.
// Flops preset to 1 so a reset looks like an idle bus.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_s,
  output logic o_sda_s,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start_det,
  output logic o_stop_det
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;

  // Synchronizer chains plus one-cycle delayed copies for edge detection
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
      r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
    end
  end

  assign o_scl_s     = r_scl_sync[SYNC_STAGES-1];
  assign o_sda_s     = r_sda_sync[SYNC_STAGES-1];
  assign o_scl_rise  =  o_scl_s & ~r_scl_d;
  assign o_scl_fall  = ~o_scl_s &  r_scl_d;
  assign o_start_det =  o_scl_s &  r_sda_d & ~o_sda_s;
  assign o_stop_det  =  o_scl_s & ~r_sda_d &  o_sda_s;

endmodule

// File: rtl/i2c_slave_axis.sv
// I2C target: received write bytes leave on m_axis, read bytes come from
// s_axis. SDA is open-drain via i2c_sda_oe; no clock stretching.
module i2c_slave_axis
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       i2c_scl_i,
  input  logic       i2c_sda_i,
  output logic       i2c_sda_oe,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tuser,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic       busy
);

  logic w_scl_s;
  logic w_sda_s;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start_det;
  logic w_stop_det;
  logic w_rise;
  logic [7:0] w_rd_byte;
  logic [7:0] w_rx_byte;

  i2c_slave_state_t         r_state;
  logic [I2C_BIT_CNT_W-1:0] r_bit_cnt;
  logic [7:0]               r_shift;
  logic                     r_phase;
  logic                     r_rw;
  logic                     r_first;
  logic                     r_wr_ack;
  logic                     r_sda_oe;
  logic [7:0]               r_m_tdata;
  logic                     r_m_tvalid;
  logic                     r_m_tuser;
  logic                     r_s_tready;
  logic                     r_busy;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .i_clk       (clk),
    .i_rst_n     (arst_n),
    .i_scl       (i2c_scl_i),
    .i_sda       (i2c_sda_i),
    .o_scl_s     (w_scl_s),
    .o_sda_s     (w_sda_s),
    .o_scl_rise  (w_scl_rise),
    .o_scl_fall  (w_scl_fall),
    .o_start_det (w_start_det),
    .o_stop_det  (w_stop_det)
  );

  assign w_rise    = w_scl_rise & w_scl_s;
  assign w_rx_byte = {r_shift[6:0], w_sda_s};
  assign w_rd_byte = s_axis_tvalid ? s_axis_tdata : IDLE_BYTE;

  // Protocol FSM; every load of a read byte also puts its MSB on SDA at the
  // same SCL fall, so the slot that fall opens already carries bit 7.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= 8'h00;
      r_phase    <= 1'b0;
      r_rw       <= RW_WRITE;
      r_first    <= 1'b0;
      r_wr_ack   <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_m_tdata  <= 8'h00;
      r_m_tvalid <= 1'b0;
      r_m_tuser  <= 1'b0;
      r_s_tready <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_s_tready <= 1'b0;
      if (r_m_tvalid && m_axis_tready) begin
        r_m_tvalid <= 1'b0;
        r_m_tuser  <= 1'b0;
      end

      if (w_start_det) begin
        r_state   <= ST_ADDR;
        r_bit_cnt <= '0;
        r_phase   <= 1'b0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
      end else if (w_stop_det) begin
        r_state  <= ST_IDLE;
        r_phase  <= 1'b0;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_sda_oe <= 1'b0;
          end
          ST_ADDR: begin
            if (w_rise) begin
              r_shift <= w_rx_byte;
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt <= I2C_ACK_BIT;
                r_phase   <= 1'b0;
                if (addr_match(w_rx_byte, SLAVE_ADDR)) begin
                  r_state <= ST_ADDR_ACK;
                  r_busy  <= 1'b1;
                  r_rw    <= w_sda_s;
                end else begin
                  r_state <= ST_WAIT_STOP;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (!r_phase) begin
                r_sda_oe <= 1'b1;
                r_phase  <= 1'b1;
              end else begin
                r_phase <= 1'b0;
                if (r_rw == RW_READ) begin
                  r_sda_oe   <= ~w_rd_byte[7];
                  r_shift    <= {w_rd_byte[6:0], 1'b0};
                  r_s_tready <= s_axis_tvalid;
                  r_bit_cnt  <= 4'd1;
                  r_state    <= ST_RD_DATA;
                end else begin
                  r_sda_oe  <= 1'b0;
                  r_first   <= 1'b1;
                  r_bit_cnt <= '0;
                  r_state   <= ST_WR_DATA;
                end
              end
            end
          end
          ST_WR_DATA: begin
            if (w_rise) begin
              r_shift <= w_rx_byte;
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt <= I2C_ACK_BIT;
                r_phase   <= 1'b0;
                r_state   <= ST_WR_ACK;
                // A byte still waiting downstream forces a NACK of this one
                if (!r_m_tvalid) begin
                  r_m_tdata  <= w_rx_byte;
                  r_m_tvalid <= 1'b1;
                  r_m_tuser  <= r_first;
                  r_first    <= 1'b0;
                  r_wr_ack   <= 1'b1;
                end else begin
                  r_wr_ack <= 1'b0;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          ST_WR_ACK: begin
            if (w_scl_fall) begin
              if (!r_phase) begin
                r_sda_oe <= r_wr_ack;
                r_phase  <= 1'b1;
              end else begin
                r_sda_oe  <= 1'b0;
                r_phase   <= 1'b0;
                r_bit_cnt <= '0;
                r_state   <= ST_WR_DATA;
              end
            end
          end
          ST_RD_DATA: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == I2C_ACK_BIT) begin
                r_sda_oe <= 1'b0;
                r_phase  <= 1'b0;
                r_state  <= ST_RD_ACK;
              end else begin
                r_sda_oe  <= ~r_shift[7];
                r_shift   <= {r_shift[6:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          ST_RD_ACK: begin
            if (w_rise) begin
              if (w_sda_s) begin
                r_state <= ST_WAIT_STOP;
              end else begin
                r_phase <= 1'b1;
              end
            end else if (w_scl_fall && r_phase) begin
              r_phase    <= 1'b0;
              r_sda_oe   <= ~w_rd_byte[7];
              r_shift    <= {w_rd_byte[6:0], 1'b0};
              r_s_tready <= s_axis_tvalid;
              r_bit_cnt  <= 4'd1;
              r_state    <= ST_RD_DATA;
            end
          end
          ST_WAIT_STOP: begin
            r_sda_oe <= 1'b0;
          end
          default: begin
            r_state  <= ST_IDLE;
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign i2c_sda_oe    = r_sda_oe;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tuser  = r_m_tuser;
  assign s_axis_tready = r_s_tready;
  assign busy          = r_busy;

endmodule

// File: tb/tb_i2c_slave_axis.sv
// Self-checking bench: bit-banged I2C master, AXI-Stream monitors and a
// transaction-level reference model of the target.
module tb_i2c_slave_axis;

  localparam int Q = 5;

  logic       clk;
  logic       arst_n;
  logic       i2c_scl_i;
  logic       m_sda;
  logic       i2c_sda_i;
  logic       i2c_sda_oe;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tuser;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       busy;

  int checks;
  int failures;

  logic [8:0] hs_q[$];
  logic [8:0] exp_hs_q[$];
  bit         obs_ack_q[$];
  bit         exp_ack_q[$];
  logic [7:0] wr_data_q[$];
  logic [7:0] rd_src_q[$];
  bit         rd_val_q[$];
  logic [7:0] rd_obs_q[$];
  bit         rd_addr_ack;
  int         tready_cnt;
  bit         oe_seen;
  bit         busy_seen;
  bit         tvalid_seen;

  assign i2c_sda_i = m_sda & ~i2c_sda_oe;

  i2c_slave_axis dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .i2c_scl_i     (i2c_scl_i),
    .i2c_sda_i     (i2c_sda_i),
    .i2c_sda_oe    (i2c_sda_oe),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (m_axis_tvalid && m_axis_tready) hs_q.push_back({m_axis_tuser, m_axis_tdata});
      if (s_axis_tready) tready_cnt = tready_cnt + 1;
      if (i2c_sda_oe) oe_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
      if (m_axis_tvalid) tvalid_seen = 1'b1;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_obs();
    hs_q.delete();
    tready_cnt  = 0;
    oe_seen     = 1'b0;
    busy_seen   = 1'b0;
    tvalid_seen = 1'b0;
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    m_sda = b;
    wait_clks(Q);
    i2c_scl_i = 1'b1;
    wait_clks(Q);
    s = i2c_sda_i;
    wait_clks(Q);
    i2c_scl_i = 1'b0;
    wait_clks(Q);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    i2c_scl_i = 1'b1;
    wait_clks(Q);
    m_sda = 1'b0;
    wait_clks(Q);
    i2c_scl_i = 1'b0;
    wait_clks(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    wait_clks(Q);
    i2c_scl_i = 1'b1;
    wait_clks(Q);
    m_sda = 1'b1;
    wait_clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output bit ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input bit mack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_xfer(1'b1, s);
      d = {d[6:0], s};
    end
    bit_xfer(~mack, s);
  endtask

  // START, address, wr_data_q bytes; no STOP so callers can inspect mid-bus state
  task automatic do_write(input logic [7:0] addr);
    bit a;
    obs_ack_q.delete();
    i2c_start();
    write_byte(addr, a);
    obs_ack_q.push_back(a);
    foreach (wr_data_q[k]) begin
      write_byte(wr_data_q[k], a);
      obs_ack_q.push_back(a);
    end
  endtask

  // Read rd_src_q.size() bytes from 0x50, ACK all but the last
  task automatic do_read();
    bit a;
    logic [7:0] d;
    int n;
    n = rd_src_q.size();
    rd_obs_q.delete();
    i2c_start();
    s_axis_tdata  = rd_src_q[0];
    s_axis_tvalid = rd_val_q[0];
    write_byte(8'hA1, a);
    rd_addr_ack = a;
    for (int k = 0; k < n; k++) begin
      if (k + 1 < n) begin
        s_axis_tdata  = rd_src_q[k+1];
        s_axis_tvalid = rd_val_q[k+1];
      end else begin
        s_axis_tvalid = 1'b0;
      end
      read_byte(k + 1 < n, d);
      rd_obs_q.push_back(d);
    end
  endtask

  // Reference: address hit ACKs; a byte is ACKed and delivered only if no
  // earlier byte of this transfer is still waiting downstream.
  task automatic model_write(input logic [7:0] addr, input bit rdy);
    bit hit;
    bit pending;
    bit first;
    exp_ack_q.delete();
    exp_hs_q.delete();
    hit = (addr[7:1] == 7'h50) && (addr[0] == 1'b0);
    exp_ack_q.push_back(hit);
    pending = 1'b0;
    first   = 1'b1;
    foreach (wr_data_q[k]) begin
      if (hit && !pending) begin
        exp_ack_q.push_back(1'b1);
        exp_hs_q.push_back({first, wr_data_q[k]});
        first   = 1'b0;
        pending = ~rdy;
      end else begin
        exp_ack_q.push_back(1'b0);
      end
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    wait_clks(3);
    checks++; if (i2c_sda_oe !== 1'b0) begin failures++; $display("FAIL reset_oe: got %b expected 0", i2c_sda_oe); end
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); end
    checks++; if (m_axis_tuser !== 1'b0) begin failures++; $display("FAIL reset_tuser: got %b expected 0", m_axis_tuser); end
    checks++; if (m_axis_tdata !== 8'h00) begin failures++; $display("FAIL reset_tdata: got %h expected 00", m_axis_tdata); end
    checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL reset_tready: got %b expected 0", s_axis_tready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    arst_n = 1'b1;
    wait_clks(4);
  endtask

  task automatic test_write(input string name, input logic [7:0] addr, input bit rdy);
    bit hit;
    hit = (addr[7:1] == 7'h50) && (addr[0] == 1'b0);
    m_axis_tready = rdy;
    clear_obs();
    model_write(addr, rdy);
    do_write(addr);
    checks++; if (busy !== hit) begin failures++; $display("FAIL %s_busy_mid: got %b expected %b", name, busy, hit); end
    i2c_stop();
    wait_clks(4);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s_busy_end: got %b expected 0", name, busy); end
    checks++; if (obs_ack_q.size() != exp_ack_q.size()) begin failures++; $display("FAIL %s_ack_count: got %0d expected %0d", name, obs_ack_q.size(), exp_ack_q.size()); end
    foreach (exp_ack_q[k]) if (k < obs_ack_q.size()) begin
      checks++; if (obs_ack_q[k] !== exp_ack_q[k]) begin failures++; $display("FAIL %s_ack%0d: got %b expected %b", name, k, obs_ack_q[k], exp_ack_q[k]); end
    end
    if (!rdy) begin
      checks++; if (hs_q.size() != 0) begin failures++; $display("FAIL %s_early_hs: got %0d expected 0", name, hs_q.size()); end
      checks++; if ({m_axis_tvalid, m_axis_tuser, m_axis_tdata} !== {1'b1, exp_hs_q[0]}) begin failures++; $display("FAIL %s_held: got %h expected %h", name, {m_axis_tvalid, m_axis_tuser, m_axis_tdata}, {1'b1, exp_hs_q[0]}); end
      m_axis_tready = 1'b1;
      wait_clks(4);
    end
    checks++; if (hs_q.size() != exp_hs_q.size()) begin failures++; $display("FAIL %s_hs_count: got %0d expected %0d", name, hs_q.size(), exp_hs_q.size()); end
    foreach (exp_hs_q[k]) if (k < hs_q.size()) begin
      checks++; if (hs_q[k] !== exp_hs_q[k]) begin failures++; $display("FAIL %s_hs%0d: got %h expected %h", name, k, hs_q[k], exp_hs_q[k]); end
    end
    checks++; if (busy_seen !== hit) begin failures++; $display("FAIL %s_busy_seen: got %b expected %b", name, busy_seen, hit); end
    if (!hit) begin
      checks++; if (oe_seen !== 1'b0) begin failures++; $display("FAIL %s_oe_seen: got %b expected 0", name, oe_seen); end
      checks++; if (tvalid_seen !== 1'b0) begin failures++; $display("FAIL %s_tvalid_seen: got %b expected 0", name, tvalid_seen); end
    end
  endtask

  task automatic test_read(input string name);
    int exp_tready;
    clear_obs();
    exp_tready = 0;
    foreach (rd_val_q[k]) if (rd_val_q[k]) exp_tready++;
    do_read();
    checks++; if (rd_addr_ack !== 1'b1) begin failures++; $display("FAIL %s_addr_ack: got %b expected 1", name, rd_addr_ack); end
    foreach (rd_src_q[k]) begin
      checks++;
      if (rd_obs_q[k] !== (rd_val_q[k] ? rd_src_q[k] : 8'hFF)) begin
        failures++;
        $display("FAIL %s_byte%0d: got %h expected %h", name, k, rd_obs_q[k], rd_val_q[k] ? rd_src_q[k] : 8'hFF);
      end
    end
    wait_clks(2);
    checks++; if (tready_cnt != exp_tready) begin failures++; $display("FAIL %s_tready_pulses: got %0d expected %0d", name, tready_cnt, exp_tready); end
    checks++; if ({busy, i2c_sda_oe} !== 2'b10) begin failures++; $display("FAIL %s_wait_stop: got busy,oe=%b expected 10", name, {busy, i2c_sda_oe}); end
    i2c_stop();
    wait_clks(4);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s_busy_end: got %b expected 0", name, busy); end
  endtask

  task automatic test_random_write();
    logic [7:0] addr;
    int n;
    for (int it = 0; it < 4; it++) begin
      addr = ($urandom_range(0, 2) == 0) ? {7'($urandom_range(0, 127)), 1'b0} : 8'hA0;
      n = int'($urandom_range(1, 4));
      wr_data_q.delete();
      for (int k = 0; k < n; k++) wr_data_q.push_back(8'($urandom_range(0, 255)));
      test_write("rand_wr", addr, 1'b1);
    end
  endtask

  task automatic test_random_read();
    int n;
    for (int it = 0; it < 3; it++) begin
      n = int'($urandom_range(1, 3));
      rd_src_q.delete();
      rd_val_q.delete();
      for (int k = 0; k < n; k++) begin
        rd_src_q.push_back(8'($urandom_range(0, 255)));
        rd_val_q.push_back($urandom_range(0, 3) != 0);
      end
      test_read("rand_rd");
    end
  endtask

  task automatic test_reset_mid_read();
    bit a;
    clear_obs();
    i2c_start();
    s_axis_tdata  = 8'h00;
    s_axis_tvalid = 1'b1;
    write_byte(8'hA1, a);
    checks++; if (i2c_sda_oe !== 1'b1) begin failures++; $display("FAIL rst_mid_driving: got %b expected 1", i2c_sda_oe); end
    arst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (i2c_sda_oe !== 1'b0) begin failures++; $display("FAIL rst_mid_release: got %b expected 0", i2c_sda_oe); end
    wait_clks(2);
    arst_n = 1'b1;
    s_axis_tvalid = 1'b0;
    i2c_stop();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    wr_data_q.delete();
    wr_data_q.push_back(8'h77);
    test_write("rst_fresh_wr", 8'hA0, 1'b1);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    arst_n        = 1'b0;
    i2c_scl_i     = 1'b1;
    m_sda         = 1'b1;
    m_axis_tready = 1'b1;
    s_axis_tdata  = 8'h00;
    s_axis_tvalid = 1'b0;
    clear_obs();
    wait_clks(2);

    test_reset();

    wr_data_q = '{8'h3C, 8'h5A};
    test_write("write", 8'hA0, 1'b1);

    wr_data_q = '{8'h11};
    test_write("mismatch", 8'hA2, 1'b1);

    rd_src_q = '{8'hC3, 8'h81};
    rd_val_q = '{1'b1, 1'b1};
    test_read("read");

    rd_src_q = '{8'h5A};
    rd_val_q = '{1'b0};
    test_read("underflow");

    wr_data_q = '{8'h01, 8'h02};
    test_write("backpressure", 8'hA0, 1'b0);

    test_random_write();
    test_random_read();
    test_reset_mid_read();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_slave_axis.md
Name: i2c_slave_axis

Overview:
- I2C target (slave) that answers the existing AXIS I2C master and is its bus-level counterpart.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Matches a 7-bit address and ACKs it.
- Write transfers: received bytes are emitted on an AXI-Stream master port.
- Read transfers: bytes from an AXI-Stream slave port are shifted out MSB first.
- SDA is open-drain through an output-enable. No clock stretching.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address this target responds to.
- SYNC_STAGES, 2, flip-flop stages on the SCL and SDA inputs (minimum 2).
- IDLE_BYTE, 8'hFF, byte shifted out on a read when s_axis has no valid data.

Ports:
- clk  in  1  system clock, at least 8x SCL frequency.
- arst_n  in  1  reset, synchronous, active-low.
- i2c_scl_i  in  1  SCL line level.
- i2c_sda_i  in  1  SDA line level.
- i2c_sda_oe  out  1  1 = pull SDA low, 0 = release.
- m_axis_tdata  out  8  byte received from the bus.
- m_axis_tvalid  out  1  received byte valid.
- m_axis_tready  in  1  downstream accept.
- m_axis_tuser  out  1  1 = first data byte after START.
- s_axis_tdata  in  8  byte to send on a read.
- s_axis_tvalid  in  1  byte available.
- s_axis_tready  out  1  one-cycle pulse when a byte is consumed.
- busy  out  1  1 from address match until STOP or repeated START.

Behaviour:
- Reset (arst_n=0 at a clk edge):
  - state=IDLE; i2c_sda_oe=0, m_axis_tvalid=0, m_axis_tuser=0, m_axis_tdata=0, s_axis_tready=0, busy=0.
  - Synchronizer flops preset to 1 (idle bus).
  - Reset mid-transfer releases SDA in the same cycle reset is sampled.
- Edge detection:
  - Work on the synchronized scl_s/sda_s plus one-cycle delayed copies.
  - scl_rise / scl_fall are one-cycle pulses.
  - START = sda_s falling while scl_s=1. STOP = sda_s rising while scl_s=1.
  - START and STOP take priority over bit processing in the same cycle.
- Bit timing:
  - Data is sampled on scl_rise.
  - i2c_sda_oe changes only on scl_fall, registered, so it changes 1 clk after the detected fall.
  - A 4-bit bit counter tracks positions 0..8, where 8 is the ACK slot.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
  - IDLE -> ADDR on START, from any state. Repeated START: busy=0, then re-evaluate the address.
  - ADDR: shift in 8 bits.
    - After the 8th scl_rise, if bits[7:1]==SLAVE_ADDR go to ADDR_ACK and set busy=1.
    - Otherwise go to WAIT_STOP.
  - ADDR_ACK: drive oe=1 on the next scl_fall; release on the following scl_fall.
    - R/W=0 -> WR_DATA, with the first-byte flag set.
    - R/W=1 -> RD_DATA. At the releasing scl_fall, load the shifter from s_axis_tdata and pulse s_axis_tready if s_axis_tvalid=1; otherwise load IDLE_BYTE with no tready.
  - WR_DATA: shift 8 bits in.
    - At the 8th scl_rise, if m_axis_tvalid=0: load m_axis_tdata, assert tvalid, set tuser=first flag, clear the flag, go to WR_ACK and drive ACK.
    - If m_axis_tvalid=1 (previous byte not yet accepted): drop the byte, go to WR_ACK with NACK (oe stays 0).
  - WR_ACK: at the scl_fall ending the ACK slot, release SDA and go to WR_DATA.
  - m_axis handshake: the byte holds stable until tvalid&tready; tvalid and tuser clear on the cycle after the handshake.
  - RD_DATA: on each scl_fall, drive oe = ~shifter[7] and shift left. After 8 bits, release SDA and go to RD_ACK.
  - RD_ACK: sample SDA on scl_rise.
    - 0 (master ACK): on the next scl_fall load the next byte (same rule as ADDR_ACK) and return to RD_DATA.
    - 1 (NACK): go to WAIT_STOP.
  - WAIT_STOP: oe=0. Leave only on STOP (-> IDLE) or START (-> ADDR).
  - STOP in any state: -> IDLE, oe=0, busy=0. A pending m_axis byte is kept until accepted.

Decomposition:
- Package i2c_pkg holds:
  - state enum i2c_slave_state_t;
  - constants I2C_BIT_CNT_W=4 and I2C_ACK_BIT=8;
  - RW_WRITE=1'b0 and RW_READ=1'b1.
- One sub-module, i2c_line_sync: parameterized SYNC_STAGES synchronizer plus edge detector. It outputs scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det.

Test Plan:
- Write with matching address: START, 0xA0, 0x3C, 0x5A, STOP, m_axis_tready=1 → ACK on all three slots, m_axis bytes 0x3C (tuser=1) then 0x5A (tuser=0), busy returns to 0 after STOP.
- Address mismatch: START, 0xA2, 0x11, STOP → no ACK anywhere, i2c_sda_oe stays 0, no m_axis_tvalid, busy=0 throughout.
- Read: s_axis supplies 0xC3 then 0x81, START, 0xA1, master ACKs byte 1 and NACKs byte 2 → SDA shows 11000011 then 10000001, two s_axis_tready pulses, then WAIT_STOP.
- Read underflow: s_axis_tvalid=0, START 0xA1, one byte → 0xFF shifted out, no s_axis_tready.
- Backpressure: m_axis_tready=0, write 0x01, 0x02 → 0x01 ACKed and held, 0x02 NACKed. After tready=1, only 0x01 is delivered.
- Reset mid-read: arst_n=0 while driving a 0 bit → i2c_sda_oe=0 on the next clk. After release, IDLE, and a fresh write to 0xA0 is ACKed.
